// File: rtl/fsk4_codeword_assembler.sv
// fsk4_codeword_assembler
// Framing stage after the 4-FSK demodulator. Hunts the 2-bit symbol stream
// for a 16-bit sync word, then packs the following symbols MSB-first into
// 16-bit codewords, each presented with a one-cycle cw_valid strobe. If the
// symbol stream stalls while a frame is being collected, the partial frame
// is dropped and the block goes back to hunting.
module fsk4_codeword_assembler #(
    parameter logic [15:0] SYNC_WORD   = 16'h1ACF,
    parameter int          NUM_CW      = 1,
    parameter int          TIMEOUT_CYC = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  sym_in,
    input  logic        sym_valid,
    output logic [15:0] codeword,
    output logic        cw_valid,
    output logic        sync_found,
    output logic        timeout_err,
    output logic        busy
);

    typedef enum logic {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);
    localparam logic [3:0] CW_LAST = 4'(NUM_CW - 1);
    localparam logic [3:0] FILL_MAX = 4'd8;

    state_t      state_reg;
    // Only the seven most recent symbols need to be stored: the top symbol
    // of the 16-bit window is shifted out on the very cycle it would be
    // compared, so the full window is formed from these bits plus sym_in.
    logic [13:0] hunt_reg;
    logic [3:0]  fill_reg;
    logic [13:0] asm_reg;
    logic [2:0]  sym_cnt_reg;
    logic [3:0]  cw_cnt_reg;
    logic [7:0]  to_cnt_reg;
    logic [15:0] codeword_reg;
    logic        cw_valid_reg;
    logic        sync_found_reg;
    logic        timeout_err_reg;
    logic        busy_reg;

    logic [15:0] hunt_next;
    logic [3:0]  fill_next;
    logic [15:0] asm_next;
    logic        sync_hit;

    // Candidate window/fill values including the symbol offered this cycle.
    always_comb begin
        hunt_next = {hunt_reg, sym_in};
        asm_next  = {asm_reg, sym_in};
        fill_next = (fill_reg == FILL_MAX) ? FILL_MAX : fill_reg + 4'd1;
        sync_hit  = (fill_next >= FILL_MAX) && (hunt_next == SYNC_WORD);
    end

    // Hunt/collect state machine with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= HUNT;
            hunt_reg        <= '0;
            fill_reg        <= '0;
            asm_reg         <= '0;
            sym_cnt_reg     <= '0;
            cw_cnt_reg      <= '0;
            to_cnt_reg      <= '0;
            codeword_reg    <= '0;
            cw_valid_reg    <= 1'b0;
            sync_found_reg  <= 1'b0;
            timeout_err_reg <= 1'b0;
            busy_reg        <= 1'b0;
        end else begin
            cw_valid_reg    <= 1'b0;
            sync_found_reg  <= 1'b0;
            timeout_err_reg <= 1'b0;
            case (state_reg)
                HUNT: begin
                    if (sym_valid) begin
                        if (sync_hit) begin
                            state_reg      <= COLLECT;
                            sync_found_reg <= 1'b1;
                            busy_reg       <= 1'b1;
                            sym_cnt_reg    <= '0;
                            cw_cnt_reg     <= '0;
                            to_cnt_reg     <= '0;
                            asm_reg        <= '0;
                            hunt_reg       <= '0;
                            fill_reg       <= '0;
                        end else begin
                            hunt_reg <= hunt_next[13:0];
                            fill_reg <= fill_next;
                        end
                    end
                end
                COLLECT: begin
                    if (sym_valid) begin
                        // A symbol on the timeout boundary cycle still wins.
                        to_cnt_reg <= '0;
                        if (sym_cnt_reg == 3'd7) begin
                            codeword_reg <= asm_next;
                            cw_valid_reg <= 1'b1;
                            sym_cnt_reg  <= '0;
                            asm_reg      <= '0;
                            if (cw_cnt_reg == CW_LAST) begin
                                // Frame complete: return to a clean hunt so
                                // frame data can never complete a sync.
                                state_reg  <= HUNT;
                                busy_reg   <= 1'b0;
                                cw_cnt_reg <= '0;
                                hunt_reg   <= '0;
                                fill_reg   <= '0;
                            end else begin
                                cw_cnt_reg <= cw_cnt_reg + 4'd1;
                            end
                        end else begin
                            asm_reg     <= asm_next[13:0];
                            sym_cnt_reg <= sym_cnt_reg + 3'd1;
                        end
                    end else if (to_cnt_reg == TO_LAST) begin
                        // Stream stalled: drop the partial frame silently.
                        timeout_err_reg <= 1'b1;
                        state_reg       <= HUNT;
                        busy_reg        <= 1'b0;
                        asm_reg         <= '0;
                        sym_cnt_reg     <= '0;
                        cw_cnt_reg      <= '0;
                        to_cnt_reg      <= '0;
                        hunt_reg        <= '0;
                        fill_reg        <= '0;
                    end else begin
                        to_cnt_reg <= to_cnt_reg + 8'd1;
                    end
                end
                default: state_reg <= HUNT;
            endcase
        end
    end

    assign codeword    = codeword_reg;
    assign cw_valid    = cw_valid_reg;
    assign sync_found  = sync_found_reg;
    assign timeout_err = timeout_err_reg;
    assign busy        = busy_reg;

endmodule

// File: tb/tb_fsk4_codeword_assembler.sv
// Testbench for fsk4_codeword_assembler. Two instances: dut0 with one
// codeword per frame and dut1 with three. Stimulus pushes the expected
// strobe (kind, value, cycle stamp) into a per-instance queue just before
// the symbol that should cause it; monitors pop and compare whenever a
// strobe appears.
module tb_fsk4_codeword_assembler;

    localparam logic [2:0] K_NONE = 3'b000;
    localparam logic [2:0] K_CW   = 3'b100;
    localparam logic [2:0] K_SY   = 3'b010;
    localparam logic [2:0] K_TO   = 3'b001;

    typedef struct {
        logic [2:0]  kind;
        logic [15:0] val;
        int          stamp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  sym0 = 2'd0;
    logic        val0 = 1'b0;
    logic [1:0]  sym1 = 2'd0;
    logic        val1 = 1'b0;
    logic [15:0] codeword0, codeword1;
    logic        cw_valid0, cw_valid1;
    logic        sync_found0, sync_found1;
    logic        timeout_err0, timeout_err1;
    logic        busy0, busy1;

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    fsk4_codeword_assembler #(.SYNC_WORD(16'h1ACF), .NUM_CW(1), .TIMEOUT_CYC(64)) dut0 (
        .clk(clk), .rst(rst), .sym_in(sym0), .sym_valid(val0),
        .codeword(codeword0), .cw_valid(cw_valid0), .sync_found(sync_found0),
        .timeout_err(timeout_err0), .busy(busy0)
    );

    fsk4_codeword_assembler #(.SYNC_WORD(16'h1ACF), .NUM_CW(3), .TIMEOUT_CYC(64)) dut1 (
        .clk(clk), .rst(rst), .sym_in(sym1), .sym_valid(val1),
        .codeword(codeword1), .cw_valid(cw_valid1), .sync_found(sync_found1),
        .timeout_err(timeout_err1), .busy(busy1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_ev(input string name, input exp_t e, input logic [2:0] got_k,
                            input logic [15:0] got_cw);
        n_tests++;
        $display("[TB] %s: strobes=%b cw=%h cycle=%0d", name, got_k, got_cw, cyc);
        if (got_k !== e.kind || cyc != e.stamp || (e.kind == K_CW && got_cw !== e.val)) begin
            n_fail++;
            $display("FAIL %s: got strobes=%b cw=%h cycle=%0d, required strobes=%b cw=%h cycle=%0d",
                     name, got_k, got_cw, cyc, e.kind, e.val, e.stamp);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] req);
        n_tests++;
        $display("[TB] %s: %0h", name, got);
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    // Monitor for dut0.
    always @(negedge clk) begin
        if (cw_valid0 || sync_found0 || timeout_err0) begin
            if (q0.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL dut0_event: got strobes=%b cw=%h cycle=%0d, required none",
                         {cw_valid0, sync_found0, timeout_err0}, codeword0, cyc);
            end else begin
                e0 = q0.pop_front();
                check_ev("dut0_event", e0, {cw_valid0, sync_found0, timeout_err0}, codeword0);
            end
        end
    end

    // Monitor for dut1.
    always @(negedge clk) begin
        if (cw_valid1 || sync_found1 || timeout_err1) begin
            if (q1.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL dut1_event: got strobes=%b cw=%h cycle=%0d, required none",
                         {cw_valid1, sync_found1, timeout_err1}, codeword1, cyc);
            end else begin
                e1 = q1.pop_front();
                check_ev("dut1_event", e1, {cw_valid1, sync_found1, timeout_err1}, codeword1);
            end
        end
    end

    // Called at a negedge; the symbol is taken at the next posedge, so the
    // strobe it causes is visible at stamp cyc+1.
    task automatic send0(input logic [1:0] s, input logic [2:0] k, input logic [15:0] v,
                         output int acc);
        exp_t e;
        if (k != K_NONE) begin
            e = '{kind: k, val: v, stamp: cyc + 1};
            q0.push_back(e);
        end
        sym0 = s;
        val0 = 1'b1;
        @(negedge clk);
        val0 = 1'b0;
        acc = cyc;
    endtask

    task automatic send1(input logic [1:0] s, input logic [2:0] k, input logic [15:0] v,
                         output int acc);
        exp_t e;
        if (k != K_NONE) begin
            e = '{kind: k, val: v, stamp: cyc + 1};
            q1.push_back(e);
        end
        sym1 = s;
        val1 = 1'b1;
        @(negedge clk);
        val1 = 1'b0;
        acc = cyc;
    endtask

    // Sends a word as 8 symbols MSB-first; the last symbol carries the expectation.
    task automatic send_word0(input logic [15:0] w, input logic [2:0] k, input logic [15:0] v,
                              input bit gappy, output int acc);
        logic [15:0] t;
        t = w;
        for (int i = 0; i < 8; i++) begin
            if (gappy) repeat (2 + (i % 4)) @(negedge clk);
            send0(t[15:14], (i == 7) ? k : K_NONE, v, acc);
            t = t << 2;
        end
    endtask

    task automatic send_word1(input logic [15:0] w, input logic [2:0] k, input logic [15:0] v,
                              output int acc);
        logic [15:0] t;
        t = w;
        for (int i = 0; i < 8; i++) begin
            send1(t[15:14], (i == 7) ? k : K_NONE, v, acc);
            t = t << 2;
        end
    endtask

    logic [1:0] sync_syms[8];
    logic [1:0] basic_data[8];
    int acc;
    exp_t te;

    initial begin
        sync_syms  = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd3, 2'd0, 2'd3, 2'd3};
        basic_data = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd0, 2'd3, 2'd1, 2'd2};

        // Reset state.
        @(negedge clk);
        check_val("reset_codeword", 32'(codeword0), 32'h0);
        check_val("reset_strobes", 32'({cw_valid0, sync_found0, timeout_err0, busy0}), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Basic frame, consecutive symbols.
        for (int i = 0; i < 8; i++) send0(sync_syms[i], (i == 7) ? K_SY : K_NONE, 16'h0, acc);
        check_val("basic_busy_after_sync", 32'(busy0), 32'h1);
        for (int i = 0; i < 8; i++) send0(basic_data[i], (i == 7) ? K_CW : K_NONE, 16'h5A36, acc);
        check_val("basic_busy_at_cw", 32'(busy0), 32'h0);

        // Back-to-back frame: first sync symbol on the cycle after cw_valid.
        send_word0(16'h1ACF, K_SY, 16'h0, 1'b0, acc);
        send_word0(16'hE41B, K_CW, 16'hE41B, 1'b0, acc);
        repeat (2) @(negedge clk);
        check_val("b2b_busy_after", 32'(busy0), 32'h0);
        check_val("b2b_codeword_held", 32'(codeword0), 32'hE41B);

        // Sliding sync with garbage prefix and 2-5 cycle gaps.
        for (int i = 0; i < 3; i++) begin
            repeat (2 + i) @(negedge clk);
            send0(2'd3, K_NONE, 16'h0, acc);
        end
        send_word0(16'h1ACF, K_SY, 16'h0, 1'b1, acc);
        send_word0(16'h5A36, K_CW, 16'h5A36, 1'b1, acc);
        repeat (2) @(negedge clk);

        // Partial fill right after reset: no sync expected.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 3; i < 8; i++) send0(sync_syms[i], K_NONE, 16'h0, acc);
        repeat (3) @(negedge clk);
        check_val("partial_busy", 32'(busy0), 32'h0);

        // Timeout after 3 data symbols.
        send_word0(16'h1ACF, K_SY, 16'h0, 1'b0, acc);
        send0(2'd1, K_NONE, 16'h0, acc);
        send0(2'd1, K_NONE, 16'h0, acc);
        send0(2'd2, K_NONE, 16'h0, acc);
        repeat (63) @(negedge clk);
        check_val("timeout_busy_before", 32'(busy0), 32'h1);
        te = '{kind: K_TO, val: 16'h0, stamp: cyc + 1};
        q0.push_back(te);
        @(negedge clk);
        check_val("timeout_busy_at", 32'(busy0), 32'h0);
        repeat (2) @(negedge clk);

        // Symbol arriving on the boundary cycle: no timeout.
        send_word0(16'h1ACF, K_SY, 16'h0, 1'b0, acc);
        send0(2'd1, K_NONE, 16'h0, acc);
        send0(2'd1, K_NONE, 16'h0, acc);
        send0(2'd2, K_NONE, 16'h0, acc);
        repeat (63) @(negedge clk);
        send0(2'd2, K_NONE, 16'h0, acc);
        send0(2'd0, K_NONE, 16'h0, acc);
        send0(2'd3, K_NONE, 16'h0, acc);
        send0(2'd1, K_NONE, 16'h0, acc);
        send0(2'd2, K_CW, 16'h5A36, acc);
        check_val("boundary_busy", 32'(busy0), 32'h0);
        repeat (2) @(negedge clk);

        // Multi-codeword frame on dut1, data includes the sync pattern.
        send_word1(16'h1ACF, K_SY, 16'h0, acc);
        send_word1(16'h1ACF, K_CW, 16'h1ACF, acc);
        check_val("multi_busy_mid", 32'(busy1), 32'h1);
        send_word1(16'h5A36, K_CW, 16'h5A36, acc);
        send_word1(16'hC3A5, K_CW, 16'hC3A5, acc);
        check_val("multi_busy_end", 32'(busy1), 32'h0);
        repeat (3) @(negedge clk);

        // Reset mid-frame after the 5th data symbol.
        send_word0(16'h1ACF, K_SY, 16'h0, 1'b0, acc);
        for (int i = 0; i < 5; i++) send0(basic_data[i], K_NONE, 16'h0, acc);
        #2 rst = 1'b1;
        #1;
        check_val("midreset_codeword", 32'(codeword0), 32'h0);
        check_val("midreset_outs", 32'({cw_valid0, sync_found0, timeout_err0, busy0}), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_word0(16'h1ACF, K_SY, 16'h0, 1'b0, acc);
        send_word0(16'hE41B, K_CW, 16'hE41B, 1'b0, acc);
        repeat (5) @(negedge clk);

        check_val("dut0_pending_events", 32'(q0.size()), 32'h0);
        check_val("dut1_pending_events", 32'(q1.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fsk4_codeword_assembler.md
# fsk4_codeword_assembler

Receive-side framing stage between the 4-FSK symbol demodulator and the CRC-8 codeword checker. It hunts the demodulated 2-bit symbol stream for a 16-bit sync word. After sync it packs the following symbols, MSB-first, into 16-bit codewords (8 data bits + 8 CRC bits) and presents each codeword with a one-cycle valid strobe to the downstream CRC check. A symbol-gap timeout aborts partial frames.

## Interface
- `SYNC_WORD`, 16'h1ACF, sync pattern as 8 symbols, first symbol in bits [15:14].
- `NUM_CW`, 1, codewords collected per detected sync (1..15).
- `TIMEOUT_CYC`, 64, max clock cycles between accepted symbols while collecting (2..255).
- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  reset. Asynchronous and active-high.
- `sym_in`  in  2  demodulated 4-FSK symbol, MSB = earlier bit.
- `sym_valid`  in  1  `sym_in` valid this cycle. May be high on any cycle, including back-to-back cycles.
- `codeword`  out  16  assembled codeword, held until the next `cw_valid`.
- `cw_valid`  out  1  one-cycle strobe: `codeword` is new.
- `sync_found`  out  1  one-cycle strobe: sync matched.
- `timeout_err`  out  1  one-cycle strobe: partial frame discarded.
- `busy`  out  1  high while in COLLECT.

## Operation
- States: HUNT and COLLECT. Reset enters HUNT.
- HUNT:
  - Each accepted symbol shifts into a 16-bit hunt register: `{hunt[13:0], sym_in}`.
  - A 4-bit fill counter saturates at 8.
  - A match is declared only when the fill counter, including the current symbol, is ≥8 and the new register value equals `SYNC_WORD`.
  - On a match: go to COLLECT, clear the symbol counter, clear the codeword counter, clear the timeout counter.
- COLLECT:
  - Each accepted symbol shifts into the 16-bit assembly register.
  - On the 8th symbol, the full value is copied to `codeword` and `cw_valid` pulses.
  - The codeword counter then increments. When it reaches `NUM_CW`, go to HUNT; otherwise continue collecting.
- Entry to HUNT by any path clears the hunt register and the fill counter. A sync therefore never reuses symbols that came before or inside a frame.
- Timeout counter:
  - Runs only in COLLECT. It resets to 0 on every accepted symbol and otherwise increments.
  - When it reaches `TIMEOUT_CYC - 1` on a cycle with no `sym_valid`: pulse `timeout_err`, discard the partial assembly, go to HUNT. `cw_valid` does not fire.
  - If `sym_valid` arrives on that same cycle, the symbol is accepted and no timeout occurs.
- There is no backpressure. Downstream must sample `codeword` on `cw_valid`.

## Timing
- Reset values: `codeword` = 16'h0000; `cw_valid`, `sync_found`, `timeout_err`, `busy` = 0. All internal counters and registers are 0.
- `sync_found` goes high the cycle after the matching symbol. `busy` rises the same cycle and stays high through the last symbol of the last codeword.
- `cw_valid` and the new `codeword` appear the cycle after the 8th symbol of a codeword is accepted.
- `busy` falls the same cycle `cw_valid` of the final codeword is high.
- Back-to-back frames:
  - A symbol on the cycle after the final `cw_valid` is already processed in HUNT.
  - Minimum spacing from the end of one frame to the next `sync_found` is 8 symbols.
- A symbol on the same cycle the timeout fires is impossible by the rule above. The symbol on the next cycle is processed in HUNT.
- `rst` asserted mid-frame clears everything immediately (asynchronously). No strobe is emitted for the aborted frame.
- Output strobes are never high simultaneously except `cw_valid` with nothing else.

## Test plan
- Basic frame: after reset, send symbols 0,1,2,2,3,0,3,3 (sync 16'h1ACF), then 1,1,2,2,0,3,1,2 on consecutive cycles. Required: `sync_found` 1 cycle after the 8th symbol; `cw_valid` with `codeword` = 16'h5A36 1 cycle after the 16th; `busy` low afterwards.
- Sliding sync: prefix 3 garbage symbols 3,3,3 before the sync, with gaps of 2-5 cycles between symbols. Required: exactly one `sync_found`, and the codeword is correct.
- Partial fill: after reset, send only the last 5 symbols of the sync (2,3,0,3,3) following reset-cleared state. Required: no `sync_found`.
- Timeout: after sync send 3 symbols, then idle. Required: `timeout_err` after exactly `TIMEOUT_CYC` = 64 cycles of no symbol, no `cw_valid`, return to HUNT. Repeat with a symbol arriving on the boundary cycle. Required: no timeout.
- Multi-codeword: `NUM_CW` = 3, sync + 24 symbols. Required: three `cw_valid` pulses with correct values. A sync pattern embedded in the data is not detected as sync.
- Reset mid-frame: assert `rst` after the 5th data symbol. Required: all outputs 0 immediately, no strobe. A following full frame decodes normally.
